uart_tx_ext: RTL and testbench

UART_TX_EXT -- requirements
Module: uart_tx_ext

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_bit_timer.sv | 37 +++
 rtl/uart_tx_ext.sv | 155 +++++++++++++++
 tb/tb_uart_tx_ext.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART blocks.
// The PARITY state only exists when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int unsigned DEF_CLK_PER_BIT = 16;
  localparam int unsigned DEF_DATA_W      = 8;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd4
  } tx_state_e;
`endif

  // Encoding 2'b11 is not a member and behaves as PAR_NONE.
  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } par_mode_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter shared by the UART TX (and later RX): bit_end is a registered
// flag high during the last cycle of each CLK_PER_BIT-cycle bit.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = DEF_CLK_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic bit_end,
  output logic bit_pre_end_c
);

  localparam int unsigned      CNT_W = $clog2(CLK_PER_BIT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Second-to-last cycle of a bit; lets the owner register flags for the last one.
  assign bit_pre_end_c = en && (cnt == LAST - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt     <= '0;
      bit_end <= 1'b0;
    end else if (en) begin
      bit_end <= bit_pre_end_c;
      cnt     <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end else begin
      cnt     <= '0;
      bit_end <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_tx_ext.sv
// UART transmitter with valid/ready payload handshake, optional 2 stop bits and,
// when UART_TX_PARITY_EN is defined, an even/odd parity bit.
module uart_tx_ext
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = DEF_CLK_PER_BIT,
  parameter int unsigned DATA_W      = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  input  logic [1:0]        parity_mode_i,
  input  logic              two_stop_i,
  output logic              tx_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned      IDX_W    = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  tx_state_e         state;
  logic [DATA_W-1:0] shreg;
  logic [IDX_W-1:0]  bit_idx;
  logic              two_stop_q;
  logic              stop_idx;
  logic              take_c;
  logic              last_stop_c;
  logic              timer_en_c;
  logic              bit_end;
  logic              bit_pre_end_c;

`ifdef UART_TX_PARITY_EN
  logic par_en_q;
  logic par_bit_q;
`else
  logic unused_parity_mode;
  assign unused_parity_mode = ^parity_mode_i;
`endif

  assign take_c      = tx_valid_i && tx_ready_o;
  assign timer_en_c  = (state != IDLE);
  assign last_stop_c = (state == STOP) && (!two_stop_q || stop_idx);

  uart_bit_timer #(
    .CLK_PER_BIT(CLK_PER_BIT)
  ) u_bit_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (take_c),
    .en           (timer_en_c),
    .bit_end      (bit_end),
    .bit_pre_end_c(bit_pre_end_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      tx_o       <= 1'b1;
      tx_ready_o <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      shreg      <= '0;
      bit_idx    <= '0;
      two_stop_q <= 1'b0;
      stop_idx   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
      if (take_c) begin
        // Accepted either from IDLE or in the last stop cycle (back-to-back).
        state      <= START;
        tx_o       <= 1'b0;
        tx_ready_o <= 1'b0;
        busy_o     <= 1'b1;
        shreg      <= tx_data_i;
        bit_idx    <= '0;
        stop_idx   <= 1'b0;
        two_stop_q <= two_stop_i;
`ifdef UART_TX_PARITY_EN
        par_en_q   <= (parity_mode_i == PAR_EVEN) || (parity_mode_i == PAR_ODD);
        par_bit_q  <= (^tx_data_i) ^ (parity_mode_i == PAR_ODD);
`endif
      end else begin
        case (state)
          IDLE: begin
            tx_o       <= 1'b1;
            busy_o     <= 1'b0;
            tx_ready_o <= 1'b1;
          end
          START: begin
            if (bit_end) begin
              state <= DATA;
              tx_o  <= shreg[0];
            end
          end
          DATA: begin
            if (bit_end) begin
              if (bit_idx == LAST_IDX) begin
                state <= STOP;
                tx_o  <= 1'b1;
`ifdef UART_TX_PARITY_EN
                if (par_en_q) begin
                  state <= PARITY;
                  tx_o  <= par_bit_q;
                end
`endif
              end else begin
                bit_idx <= bit_idx + IDX_W'(1);
                shreg   <= shreg >> 1;
                tx_o    <= shreg[1];
              end
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: begin
            if (bit_end) begin
              state <= STOP;
              tx_o  <= 1'b1;
            end
          end
`endif
          STOP: begin
            // Flag the final cycle of the last stop bit one cycle ahead.
            if (bit_pre_end_c && last_stop_c) begin
              tx_ready_o <= 1'b1;
              done_o     <= 1'b1;
            end
            if (bit_end) begin
              if (last_stop_c) begin
                state  <= IDLE;
                tx_o   <= 1'b1;
                busy_o <= 1'b0;
              end else begin
                stop_idx <= 1'b1;
              end
            end
          end
          default: begin
            state      <= IDLE;
            tx_o       <= 1'b1;
            busy_o     <= 1'b0;
            tx_ready_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_ext.sv
// Directed bench for uart_tx_ext (CLK_PER_BIT=4, DATA_W=8); expectations depend on
// whether UART_TX_PARITY_EN is defined for the build.
`timescale 1ns/1ps
module tb_uart_tx_ext;

  localparam int unsigned CPB = 4;
  localparam int unsigned DW  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] tx_data_i;
  logic          tx_valid_i;
  logic          tx_ready_o;
  logic [1:0]    parity_mode_i;
  logic          two_stop_i;
  logic          tx_o;
  logic          busy_o;
  logic          done_o;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  mode;
    logic        ts;
    logic [0:23] seq;
    int          nbits;
    int          hold;
  } vec_t;

  vec_t vecs[6];

  uart_tx_ext #(
    .CLK_PER_BIT(CPB),
    .DATA_W     (DW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tx_data_i    (tx_data_i),
    .tx_valid_i   (tx_valid_i),
    .tx_ready_o   (tx_ready_o),
    .parity_mode_i(parity_mode_i),
    .two_stop_i   (two_stop_i),
    .tx_o         (tx_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (tx_ready_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_ready_wait"}, 32'(tx_ready_o === 1'b1), 32'd1);
  endtask

  // Offer d1 for transfer, then check every cycle against the level sequence.
  task automatic run_frame(input string name,
                           input logic [7:0] d1, input logic [1:0] m1, input logic t1,
                           input logic [7:0] d2, input logic [1:0] m2, input logic t2,
                           input logic [0:23] seq, input int nbits, input int fbits,
                           input int hold);
    int total, fcyc, bad_tx, bad_busy, bad_rdy, bad_done, first_done;
    logic fin;
    total = nbits * CPB;
    fcyc  = fbits * CPB;
    bad_tx = 0; bad_busy = 0; bad_rdy = 0; bad_done = 0; first_done = 0;
    wait_ready(name);
    tx_data_i     = d1;
    parity_mode_i = m1;
    two_stop_i    = t1;
    tx_valid_i    = 1'b1;
    for (int c = 1; c <= total; c++) begin
      @(negedge clk);
      fin = ((c % fcyc) == 0);
      if (tx_o !== seq[(c - 1) / CPB]) bad_tx++;
      if (busy_o !== 1'b1) bad_busy++;
      if (tx_ready_o !== fin) bad_rdy++;
      if (done_o !== fin) bad_done++;
      if (done_o === 1'b1 && first_done == 0) first_done = c;
      if (c == 1) begin
        tx_data_i     = d2;
        parity_mode_i = m2;
        two_stop_i    = t2;
      end
      if (c == hold) tx_valid_i = 1'b0;
    end
    check({name, "_tx_bad_cycles"},   32'(bad_tx),   32'd0);
    check({name, "_busy_bad_cycles"}, 32'(bad_busy), 32'd0);
    check({name, "_ready_bad_cycles"}, 32'(bad_rdy), 32'd0);
    check({name, "_done_bad_cycles"}, 32'(bad_done), 32'd0);
    check({name, "_first_done_cycle"}, 32'(first_done), 32'(fcyc));
    @(negedge clk);
    check({name, "_idle_after"}, 32'({tx_o, busy_o, tx_ready_o, done_o}), 32'b1010);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit par;
`ifdef UART_TX_PARITY_EN
    par = 1'b1;
`else
    par = 1'b0;
`endif
    vecs[0] = '{8'hA5, 2'b00, 1'b0, {12'b0101_0010_1100, 12'b0}, 10, 1};
    vecs[1] = par ? '{8'hA5, 2'b01, 1'b0, {12'b0101_0010_1010, 12'b0}, 11, 1}
                  : '{8'hA5, 2'b01, 1'b0, {12'b0101_0010_1100, 12'b0}, 10, 1};
    vecs[2] = par ? '{8'hA5, 2'b10, 1'b0, {12'b0101_0010_1110, 12'b0}, 11, 1}
                  : '{8'hA5, 2'b10, 1'b0, {12'b0101_0010_1100, 12'b0}, 10, 1};
    vecs[3] = '{8'h00, 2'b00, 1'b1, {12'b0000_0000_0110, 12'b0}, 11, 1};
    vecs[4] = '{8'hFF, 2'b11, 1'b0, {12'b0111_1111_1100, 12'b0}, 10, 30};
    vecs[5] = par ? '{8'h5A, 2'b10, 1'b1, {12'b0010_1101_0111, 12'b0}, 12, 1}
                  : '{8'h5A, 2'b10, 1'b1, {12'b0010_1101_0110, 12'b0}, 11, 1};

    rst_n         = 1'b0;
    tx_data_i     = '0;
    tx_valid_i    = 1'b0;
    parity_mode_i = 2'b00;
    two_stop_i    = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({tx_o, busy_o, tx_ready_o, done_o}), 32'b1000);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("idle_after_reset", 32'({tx_o, busy_o, tx_ready_o, done_o}), 32'b1010);

    for (int i = 0; i < 6; i++) begin
      run_frame($sformatf("vec%0d", i),
                vecs[i].data, vecs[i].mode, vecs[i].ts,
                ~vecs[i].data, ~vecs[i].mode, ~vecs[i].ts,
                vecs[i].seq, vecs[i].nbits, vecs[i].nbits, vecs[i].hold);
    end

    // Back-to-back: valid held, 8'h55 then 8'h0F with no idle cycle between frames.
    run_frame("b2b", 8'h55, 2'b00, 1'b0, 8'h0F, 2'b00, 1'b0,
              {20'b0101010101_0111100001, 4'b0}, 20, 10, 41);

    // Reset in cycle 17 of a frame aborts it.
    wait_ready("rst_mid");
    tx_data_i     = 8'hA5;
    parity_mode_i = 2'b00;
    two_stop_i    = 1'b0;
    tx_valid_i    = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 1) tx_valid_i = 1'b0;
      if (c == 9) check("rst_mid_frame_running", 32'(tx_o), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_abort", 32'({tx_o, busy_o, tx_ready_o, done_o}), 32'b1000);
    rst_n = 1'b1;
    run_frame("after_rst", 8'h3C, 2'b00, 1'b0, 8'hC3, 2'b00, 1'b0,
              {12'b0001_1110_0100, 12'b0}, 10, 10, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
